cache_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single SRAM-like memory port of the AXI bridge between the instruction cache (read-only) and the data cache (read/write, including dirty-line write-backs). It sits between the cache-side `*_req/*_addr_ok/*_data_ok` interfaces and the bridge. It allows one outstanding transaction at a time, locks the grant across the address handshake, uses round-robin priority, and routes `data_ok`/`rdata` back to the owner.

---
 rtl/cache_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Round-robin arbiter sharing one SRAM-like bridge port between
//            the I-cache and D-cache, one outstanding transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // instruction cache
   input  logic              inst_req,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   // data cache
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   // bridge
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR_I = 3'd1,
      S_ADDR_D = 3'd2,
      S_DATA_I = 3'd3,
      S_DATA_D = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   last_grant_q, last_grant_d;   // 0 = inst, 1 = data
   logic   sel_inst, sel_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      sel_inst     = 1'b0;
      sel_data     = 1'b0;
      mem_req      = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (inst_req || data_req) begin
               // On a tie the side that did not win last time goes first.
               if (data_req && (!inst_req || !last_grant_q)) begin
                  sel_data = 1'b1;
               end else begin
                  sel_inst = 1'b1;
               end
               mem_req      = 1'b1;
               last_grant_d = sel_data;
               if (mem_addr_ok) begin
                  inst_addr_ok = sel_inst;
                  data_addr_ok = sel_data;
                  state_d      = sel_data ? S_DATA_D : S_DATA_I;
               end else begin
                  state_d      = sel_data ? S_ADDR_D : S_ADDR_I;
               end
            end
         end
         S_ADDR_I: begin
            sel_inst = 1'b1;
            mem_req  = inst_req;
            if (inst_req && mem_addr_ok) begin
               inst_addr_ok = 1'b1;
               state_d      = S_DATA_I;
            end
         end
         S_ADDR_D: begin
            sel_data = 1'b1;
            mem_req  = data_req;
            if (data_req && mem_addr_ok) begin
               data_addr_ok = 1'b1;
               state_d      = S_DATA_D;
            end
         end
         S_DATA_I: begin
            inst_data_ok = mem_data_ok;
            if (mem_data_ok) begin
               state_d = S_IDLE;
            end
         end
         S_DATA_D: begin
            data_data_ok = mem_data_ok;
            if (mem_data_ok) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Reset silences every output, whatever the inputs are doing.
      if (rst) begin
         sel_inst     = 1'b0;
         sel_data     = 1'b0;
         mem_req      = 1'b0;
         inst_addr_ok = 1'b0;
         inst_data_ok = 1'b0;
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
      end
   end

   assign mem_addr   = sel_data ? data_addr : (sel_inst ? inst_addr : '0);
   assign mem_size   = sel_data ? data_size : (sel_inst ? inst_size : 2'b00);
   assign mem_wr     = sel_data & data_wr;
   assign mem_wdata  = sel_data ? data_wdata : '0;

   assign inst_rdata = rst ? '0 : mem_rdata;
   assign data_rdata = rst ? '0 : mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Directed plus randomized checks of cache_mem_arbiter against a
//            transaction-level ownership model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_req = 1'b0;
   logic [1:0]  inst_size = 2'd2;
   logic [31:0] inst_addr = '0;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [1:0]  data_size = 2'd2;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_addr_ok = 1'b0;
   logic        mem_data_ok = 1'b0;

   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;

   int total = 0;
   int bad   = 0;

   // Model: owner 0 = none, 1 = inst, 2 = data; last winner uses same codes.
   int m_owner = 0;
   bit m_acc   = 1'b0;
   int m_last  = 1;

   cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok)
   );

   always #5 clk = ~clk;

   logic [135:0] obs;
   assign obs = {mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
                 inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                 inst_rdata, data_rdata};

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   // Compare every output against the model at the falling edge, then step.
   task automatic cyc(input string tag);
      logic        e_req, e_wr, e_iao, e_ido, e_dao, e_ddo, rq;
      logic [1:0]  e_size;
      logic [31:0] e_addr, e_wdata, e_rd;
      logic [135:0] ex;
      int cur, n_owner, n_last;
      bit n_acc;
      @(negedge clk);
      {e_req, e_wr, e_iao, e_ido, e_dao, e_ddo, rq} = '0;
      e_size = '0; e_addr = '0; e_wdata = '0; e_rd = '0;
      n_owner = m_owner; n_acc = m_acc; n_last = m_last;
      if (rst) begin
         n_owner = 0; n_acc = 1'b0; n_last = 1;
      end else begin
         e_rd = mem_rdata;
         cur  = m_owner;
         if (m_owner == 0) begin
            if (inst_req && data_req) cur = (m_last == 1) ? 2 : 1;
            else if (inst_req)        cur = 1;
            else if (data_req)        cur = 2;
            else                      cur = 0;
            if (cur != 0) n_last = cur;
         end
         if (cur != 0 && !(m_owner != 0 && m_acc)) begin
            rq     = (cur == 1) ? inst_req : data_req;
            e_req  = rq;
            e_addr = (cur == 1) ? inst_addr : data_addr;
            e_size = (cur == 1) ? inst_size : data_size;
            e_wr   = (cur == 2) && data_wr;
            e_wdata = (cur == 2) ? data_wdata : 32'h0;
            n_owner = cur;
            n_acc   = rq && mem_addr_ok;
            if (rq && mem_addr_ok) begin
               e_iao = (cur == 1);
               e_dao = (cur == 2);
            end
         end else if (m_owner != 0 && m_acc) begin
            e_ido = (m_owner == 1) && mem_data_ok;
            e_ddo = (m_owner == 2) && mem_data_ok;
            if (mem_data_ok) begin
               n_owner = 0; n_acc = 1'b0;
            end
         end
      end
      ex = {e_req, e_wr, e_size, e_addr, e_wdata, e_iao, e_ido, e_dao, e_ddo, e_rd, e_rd};
      total++;
      assert (obs === ex) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, ex);
      end
      @(posedge clk);
      #1;
      m_owner = n_owner; m_acc = n_acc; m_last = n_last;
   endtask

   initial begin
      // 1. reset with both requests high
      inst_req = 1'b1; data_req = 1'b1;
      inst_addr = 32'hBFC0_0000; data_addr = 32'h0000_1000; data_wr = 1'b1;
      data_wdata = 32'h1234_5678; mem_rdata = 32'hA5A5_5A5A;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      settle();
      chk("rst_outputs", {63'b0, |obs}, 64'd0);
      cyc("reset0");
      cyc("reset1");
      rst = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      settle();
      chk("rst_first_grant", {32'b0, mem_addr}, {32'b0, data_addr});
      chk("rst_first_req", {63'b0, mem_req}, 64'd1);
      mem_addr_ok = 1'b1;
      cyc("first_addr");
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      cyc("first_data");
      mem_data_ok = 1'b0;
      cyc("idle0");

      // 2. instruction read
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
      settle();
      chk("iread_addr_ok", {63'b0, inst_addr_ok}, 64'd1);
      cyc("iread_c0");
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      cyc("iread_c1");
      cyc("iread_c2");
      mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001;
      settle();
      chk("iread_data_ok", {63'b0, inst_data_ok}, 64'd1);
      chk("iread_rdata", {32'b0, inst_rdata}, 64'h2408_0001);
      chk("iread_no_dok", {63'b0, data_data_ok}, 64'd0);
      cyc("iread_c3");
      mem_data_ok = 1'b0;
      cyc("iread_idle");

      // 3. round robin with both requests held
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
      inst_addr = 32'h0000_0400; data_addr = 32'h0000_0800;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("rr_grant", {32'b0, mem_addr}, (k % 2 == 0) ? 64'h800 : 64'h400);
         chk("rr_wr", {63'b0, mem_wr}, (k % 2 == 0) ? 64'd1 : 64'd0);
         cyc("rr_addr");
         cyc("rr_data");
      end
      inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      cyc("rr_idle");

      // 4. grant lock while address acceptance is delayed
      inst_req = 1'b1; inst_addr = 32'h0000_1000; data_addr = 32'h0000_3000;
      cyc("lock_c0");
      data_req = 1'b1;
      for (int k = 1; k < 3; k++) begin
         settle();
         chk("lock_addr", {32'b0, mem_addr}, 64'h1000);
         cyc("lock_wait");
      end
      mem_addr_ok = 1'b1;
      settle();
      chk("lock_iaddr_ok", {62'b0, inst_addr_ok, data_addr_ok}, 64'd2);
      cyc("lock_c3");
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      settle();
      chk("lock_no_req", {63'b0, mem_req}, 64'd0);
      cyc("lock_data_wait");
      mem_data_ok = 1'b1;
      settle();
      chk("lock_idata_ok", {63'b0, inst_data_ok}, 64'd1);
      cyc("lock_data");
      mem_data_ok = 1'b0;
      settle();
      chk("lock_then_data", {32'b0, mem_addr}, 64'h3000);
      mem_addr_ok = 1'b1;
      cyc("lock_d_addr");
      data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      cyc("lock_d_data");
      mem_data_ok = 1'b0;

      // 5. dirty write-back then refill
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_1004;
      data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1'b1;
      settle();
      chk("wb_wr", {63'b0, mem_wr}, 64'd1);
      chk("wb_wdata", {32'b0, mem_wdata}, 64'hDEAD_BEEF);
      cyc("wb_addr");
      data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      settle();
      chk("wb_dok", {62'b0, data_data_ok, inst_data_ok}, 64'd2);
      cyc("wb_data");
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2004;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
      settle();
      chk("rf_wr", {63'b0, mem_wr}, 64'd0);
      chk("rf_addr", {32'b0, mem_addr}, 64'h2004);
      cyc("rf_addr_c");
      data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_CAFE;
      settle();
      chk("rf_dok", {62'b0, data_data_ok, inst_data_ok}, 64'd2);
      cyc("rf_data");
      mem_data_ok = 1'b0;
      cyc("rf_idle");

      // 6. stray data_ok in IDLE, then reset during DATA_D
      mem_data_ok = 1'b1;
      settle();
      chk("stray_idle", {62'b0, inst_data_ok, data_data_ok}, 64'd0);
      cyc("stray_c");
      mem_data_ok = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b1;
      cyc("rstmid_addr");
      data_req = 1'b0; mem_addr_ok = 1'b0; rst = 1'b1;
      cyc("rstmid_rst");
      rst = 1'b0; mem_data_ok = 1'b1;
      settle();
      chk("rstmid_late_dok", {62'b0, inst_data_ok, data_data_ok}, 64'd0);
      cyc("rstmid_late");
      mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_0040;
      settle();
      chk("rstmid_idle_grant", {31'b0, mem_req, mem_addr}, {31'b0, 1'b1, 32'h40});
      mem_addr_ok = 1'b1;
      cyc("rstmid_i_addr");
      inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      cyc("rstmid_i_data");
      mem_data_ok = 1'b0;

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst         = ($urandom_range(0, 59) == 0);
         inst_req    = ($urandom_range(0, 2) != 0);
         data_req    = ($urandom_range(0, 2) != 0);
         data_wr     = $urandom_range(0, 1) == 1;
         inst_size   = 2'($urandom_range(0, 3));
         data_size   = 2'($urandom_range(0, 3));
         inst_addr   = $urandom;
         data_addr   = $urandom;
         data_wdata  = $urandom;
         mem_rdata   = $urandom;
         mem_addr_ok = $urandom_range(0, 1) == 1;
         mem_data_ok = ($urandom_range(0, 2) == 0);
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
